// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program counter.
//   br_type_e  - branch type encodings driven by decode
//   pc_state_e - state of the PC register FSM
//   pc_shift() - log2 of the instruction size, i.e. how far instruction
//                counts are shifted to become byte offsets
package pc_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_EQ     = 2'b01,
    BR_NE     = 2'b10,
    BR_ALWAYS = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } pc_state_e;

  function automatic int pc_shift(input int instr_bytes);
    return $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: purely combinational next-PC target generator.
// Builds the sequential, branch, absolute-jump and register-jump targets
// for the current pc and picks one by priority
// (jump_reg > jump > taken branch > sequential).
// Ports:
//   pc          in   current program counter
//   ctl_valid   in   control inputs qualify this pc (already gated by caller)
//   br_type     in   branch type (pc_pkg::br_type_e encoding)
//   zero_flag   in   ALU zero flag
//   jump        in   absolute jump
//   jump_reg    in   register jump
//   imm         in   branch offset in instructions, sign-extended
//   jidx        in   jump index in instructions
//   reg_target  in   register jump target
//   pc4         out  pc + INSTR_BYTES
//   target      out  priority-selected next pc
//   taken       out  a redirect is selected
//   misaligned  out  reg_target has nonzero bits below instruction alignment
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int IMM_W       = 16,
  parameter int JIDX_W      = 26,
  parameter int INSTR_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              ctl_valid,
  input  logic [1:0]        br_type,
  input  logic              zero_flag,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] target,
  output logic              taken,
  output logic              misaligned
);

  localparam int SHIFT = pc_shift(INSTR_BYTES);

  // Masks rather than slices so that SHIFT == 0 and
  // ADDR_W == JIDX_W + SHIFT both stay legal without empty ranges.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] HI_MASK  =
    ~((ADDR_W'(1) << (JIDX_W + SHIFT)) - ADDR_W'(1));

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] r_tgt;
  logic              br_cond;

  assign pc4        = pc + ADDR_W'(INSTR_BYTES);
  assign br_tgt     = pc4 + (ADDR_W'($signed(imm)) << SHIFT);
  assign j_tgt      = (pc4 & HI_MASK) | (ADDR_W'(jidx) << SHIFT);
  assign r_tgt      = reg_target & ~LOW_MASK;
  assign misaligned = |(reg_target & LOW_MASK);

  // Branch condition from the branch type and the ALU zero flag.
  always_comb begin
    br_cond = 1'b0;
    case (br_type_e'(br_type))
      BR_EQ:     br_cond = zero_flag;
      BR_NE:     br_cond = ~zero_flag;
      BR_ALWAYS: br_cond = 1'b1;
      default:   br_cond = 1'b0;
    endcase
  end

  assign taken = ctl_valid & (jump_reg | jump | br_cond);

  // Priority target select; falls through to pc4 when nothing redirects.
  always_comb begin
    target = pc4;
    if (ctl_valid && jump_reg)     target = r_tgt;
    else if (ctl_valid && jump)    target = j_tgt;
    else if (ctl_valid && br_cond) target = br_tgt;
  end

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered program counter for the fetch stage.
// Presents pc to instruction memory with a valid/ready handshake, advances
// it on each accepted fetch, and holds a redirect that shows up while fetch
// is stalled until the fetch is finally accepted.
// Ports:
//   clk, reset    clock (rising edge), async active-high reset
//   fetch_ready   in   instruction memory accepts current pc
//   ctl_valid     in   control inputs valid for current pc
//   br_type, zero_flag, jump, jump_reg, imm, jidx, reg_target
//                 in   redirect controls and operands
//   pc            out  current pc (registered)
//   pc_valid      out  pc presented to fetch
//   pc_plus       out  pc + INSTR_BYTES
//   taken         out  redirect selected this cycle
//   misalign_err  out  sticky: misaligned register jump applied
//   proto_err     out  sticky: ctl_valid seen while a redirect was pending
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter int                 IMM_W        = 16,
  parameter int                 JIDX_W       = 26,
  parameter int                 INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ready,
  input  logic              ctl_valid,
  input  logic [1:0]        br_type,
  input  logic              zero_flag,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              taken,
  output logic              misalign_err,
  output logic              proto_err
);

  pc_state_e         state_q;
  pc_state_e         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pending_q;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic              sel_valid;
  logic              fire;

  // Control inputs only steer the PC in RUN; in BOOT and PEND they are
  // not allowed to select a new target.
  assign sel_valid = ctl_valid & (state_q == RUN);

  pc_target_calc #(
    .ADDR_W      (ADDR_W),
    .IMM_W       (IMM_W),
    .JIDX_W      (JIDX_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_calc (
    .pc         (pc_q),
    .ctl_valid  (sel_valid),
    .br_type    (br_type),
    .zero_flag  (zero_flag),
    .jump       (jump),
    .jump_reg   (jump_reg),
    .imm        (imm),
    .jidx       (jidx),
    .reg_target (reg_target),
    .pc4        (pc_plus),
    .target     (target),
    .taken      (taken),
    .misaligned (misaligned)
  );

  assign pc       = pc_q;
  assign pc_valid = (state_q != BOOT);
  assign fire     = pc_valid & fetch_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state: BOOT lasts exactly one cycle; a redirect that cannot be
  // fetched this cycle parks in PEND until the fetch is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!fire && taken) state_d = PEND;
      PEND:    if (fire) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // PC, pending target and sticky error flags. target already equals pc4
  // when nothing is taken, so RUN can load it unconditionally on fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      pending_q    <= '0;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fire)       pc_q      <= target;
          else if (taken) pending_q <= target;
        end
        PEND: begin
          if (fire) pc_q <= pending_q;
        end
        default: ;
      endcase
      if (sel_valid && jump_reg && misaligned) misalign_err <= 1'b1;
      if (state_q == PEND && ctl_valid)        proto_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed self-checking bench for next_pc_unit.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked before the next edge; all expected values are hand-computed.
module tb_next_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_ready;
  logic        ctl_valid;
  logic [1:0]  br_type;
  logic        zero_flag;
  logic        jump;
  logic        jump_reg;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus;
  logic        taken;
  logic        misalign_err;
  logic        proto_err;

  int compare_count  = 0;
  int mismatch_count = 0;

  next_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_ready  (fetch_ready),
    .ctl_valid    (ctl_valid),
    .br_type      (br_type),
    .zero_flag    (zero_flag),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .imm          (imm),
    .jidx         (jidx),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pc_plus      (pc_plus),
    .taken        (taken),
    .misalign_err (misalign_err),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic cv, input logic [1:0] bt,
                               input logic z, input logic j, input logic jr,
                               input logic [15:0] im, input logic [25:0] ji,
                               input logic [31:0] rt);
    fetch_ready = rdy;
    ctl_valid   = cv;
    br_type     = bt;
    zero_flag   = z;
    jump        = j;
    jump_reg    = jr;
    imm         = im;
    jidx        = ji;
    reg_target  = rt;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(rdy, 1'b0, BR_NONE, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, mismatched=%0d", mismatch_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(1'b1);
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_pc", pc, 32'h0040_0000);
    checkOutput("rst_valid", 32'(pc_valid), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    checkOutput("rst_proto", 32'(proto_err), 32'd0);

    // Boot sequence; jump without ctl_valid must not redirect.
    @(negedge clk) reset = 1'b0;
    #1;
    checkOutput("boot_valid", 32'(pc_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, BR_NONE, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000010, 32'h0);
    step();
    checkOutput("seq0_pc", pc, 32'h0040_0000);
    checkOutput("seq0_valid", 32'(pc_valid), 32'd1);
    checkOutput("gated_taken", 32'(taken), 32'd0);
    checkOutput("seq0_plus", pc_plus, 32'h0040_0004);
    step();
    checkOutput("seq1_pc", pc, 32'h0040_0004);
    step();
    checkOutput("seq2_pc", pc, 32'h0040_0008);

    // Conditional branches, imm = -2 instructions.
    applyStimulus(1'b1, 1'b1, BR_EQ, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    #1 checkOutput("beq_taken", 32'(taken), 32'd1);
    step();
    checkOutput("beq_t_pc", pc, 32'h0040_0004);
    idle(1'b1);
    step();
    checkOutput("back_pc", pc, 32'h0040_0008);
    applyStimulus(1'b1, 1'b1, BR_EQ, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    #1 checkOutput("beq_nt_taken", 32'(taken), 32'd0);
    step();
    checkOutput("beq_nt_pc", pc, 32'h0040_000C);
    applyStimulus(1'b1, 1'b1, BR_NE, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    step();
    checkOutput("bne_t_pc0", pc, 32'h0040_0008);
    step();
    checkOutput("bne_t_pc1", pc, 32'h0040_0004);
    applyStimulus(1'b1, 1'b1, BR_NE, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    #1 checkOutput("bne_nt_taken", 32'(taken), 32'd0);
    step();
    checkOutput("bne_nt_pc", pc, 32'h0040_0008);
    idle(1'b1);
    step();
    step();
    checkOutput("pre_jump_pc", pc, 32'h0040_0010);

    // Jumps and priority.
    applyStimulus(1'b1, 1'b1, BR_ALWAYS, 1'b0, 1'b1, 1'b0, 16'h0010, 26'h0100040, 32'h0);
    step();
    checkOutput("jump_pc", pc, 32'h0040_0100);
    applyStimulus(1'b1, 1'b1, BR_ALWAYS, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0100040, 32'h0040_0200);
    step();
    checkOutput("jreg_prio_pc", pc, 32'h0040_0200);
    applyStimulus(1'b1, 1'b1, BR_NONE, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0040_0010);
    step();
    checkOutput("jreg_pc", pc, 32'h0040_0010);
    checkOutput("jreg_aligned_err", 32'(misalign_err), 32'd0);

    // Stalled redirect parks in PEND; ctl_valid in PEND is a protocol error.
    applyStimulus(1'b0, 1'b1, BR_NONE, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0100040, 32'h0);
    #1 checkOutput("stall_taken", 32'(taken), 32'd1);
    step();
    checkOutput("pend_pc0", pc, 32'h0040_0010);
    checkOutput("pend_valid", 32'(pc_valid), 32'd1);
    idle(1'b0);
    step();
    checkOutput("pend_pc1", pc, 32'h0040_0010);
    checkOutput("pend_proto0", 32'(proto_err), 32'd0);
    applyStimulus(1'b0, 1'b1, BR_NONE, 1'b0, 1'b1, 1'b1, 16'h0, 26'h0000010, 32'h0040_0300);
    step();
    checkOutput("pend_pc2", pc, 32'h0040_0010);
    checkOutput("pend_proto1", 32'(proto_err), 32'd1);
    idle(1'b1);
    step();
    checkOutput("pend_fire_pc", pc, 32'h0040_0100);
    step();
    checkOutput("post_pend_pc", pc, 32'h0040_0104);

    // Misaligned register jump; flag is sticky.
    applyStimulus(1'b1, 1'b1, BR_NONE, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0040_0103);
    step();
    checkOutput("misalign_pc", pc, 32'h0040_0100);
    checkOutput("misalign_set", 32'(misalign_err), 32'd1);
    idle(1'b1);
    step();
    step();
    checkOutput("misalign_seq_pc", pc, 32'h0040_0108);
    checkOutput("misalign_sticky", 32'(misalign_err), 32'd1);

    // Jump keeps the upper pc4 bits.
    applyStimulus(1'b1, 1'b1, BR_NONE, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h7FFF_FFF8);
    step();
    checkOutput("hi_jreg_pc", pc, 32'h7FFF_FFF8);
    applyStimulus(1'b1, 1'b1, BR_NONE, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000010, 32'h0);
    step();
    checkOutput("hi_jump_pc", pc, 32'h7000_0040);

    // Wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b1, BR_NONE, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'hFFFF_FFFC);
    step();
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus", pc_plus, 32'h0000_0000);
    idle(1'b1);
    step();
    checkOutput("wrap_pc", pc, 32'h0000_0000);

    // Largest forward branch offset.
    applyStimulus(1'b1, 1'b1, BR_ALWAYS, 1'b0, 1'b0, 1'b0, 16'h7FFF, 26'h0, 32'h0);
    step();
    checkOutput("max_fwd_pc", pc, 32'h0002_0000);

    // Async reset in the middle of PEND.
    applyStimulus(1'b0, 1'b1, BR_ALWAYS, 1'b0, 1'b0, 1'b0, 16'h0004, 26'h0, 32'h0);
    step();
    step();
    checkOutput("pre_rst_proto", 32'(proto_err), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_pc", pc, 32'h0040_0000);
    checkOutput("mid_rst_valid", 32'(pc_valid), 32'd0);
    checkOutput("mid_rst_misalign", 32'(misalign_err), 32'd0);
    checkOutput("mid_rst_proto", 32'(proto_err), 32'd0);
    idle(1'b1);
    @(negedge clk) reset = 1'b0;
    #1 checkOutput("reboot_valid", 32'(pc_valid), 32'd0);
    step();
    checkOutput("reseq0_pc", pc, 32'h0040_0000);
    step();
    checkOutput("reseq1_pc", pc, 32'h0040_0004);
    step();
    checkOutput("reseq2_pc", pc, 32'h0040_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
